// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - shared Mini-SRC types and constants for the divider
package mini_src_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS_A = 3'd1,
    S_ABS_B = 3'd2,
    S_ITER  = 3'd3,
    S_FIX_Q = 3'd4,
    S_FIX_R = 3'd5,
    S_DONE  = 3'd6
  } div_state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - 32-bit adder/subtractor; cout=1 on subtract means no borrow
module adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W-1:0] b_x;

  assign b_x = b ^ {DATA_W{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_x} + {{DATA_W{1'b0}}, sub};

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - restoring signed divider sequencing one shared adder
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              div_by_zero
);
  import mini_src_pkg::*;

  div_state_t        state;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] q_reg;
  logic [DATA_W-1:0] d_reg;
  logic [DATA_W-1:0] r_reg;
  logic              q_neg;
  logic              r_neg;

  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic [DATA_W-1:0] r_shift;

  // R < D <= 2^31 before each shift, so the dropped r_reg MSB is always 0
  assign r_shift = {r_reg[DATA_W-2:0], q_reg[DATA_W-1]};

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      S_ABS_A: add_b = q_reg;
      S_ABS_B: add_b = d_reg;
      S_ITER: begin
        add_a = r_shift;
        add_b = d_reg;
      end
      S_FIX_Q: add_b = q_reg;
      S_FIX_R: add_b = r_reg;
      default: add_b = '0;
    endcase
  end

  adder #(.DATA_W(DATA_W)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .sub  (1'b1),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      lo          <= '0;
      hi          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= '0;
            q_neg <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
            r_neg <= dividend[DATA_W-1];
            // Divide-by-zero results are final at once; DONE only pulses them out
            if (divisor == '0) begin
              lo          <= '1;
              hi          <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              lo          <= '0;
              hi          <= '0;
              div_by_zero <= 1'b0;
              state       <= S_ABS_A;
            end
          end
        end
        S_ABS_A: begin
          if (q_reg[DATA_W-1]) q_reg <= add_sum;
          state <= S_ABS_B;
        end
        S_ABS_B: begin
          if (d_reg[DATA_W-1]) d_reg <= add_sum;
          state <= S_ITER;
        end
        S_ITER: begin
          if (add_cout) begin
            r_reg <= add_sum;
            q_reg <= {q_reg[DATA_W-2:0], 1'b1};
          end else begin
            r_reg <= r_shift;
            q_reg <= {q_reg[DATA_W-2:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DIV_ITERS - 1)) state <= S_FIX_Q;
        end
        S_FIX_Q: begin
          if (q_neg) q_reg <= add_sum;
          state <= S_FIX_R;
        end
        S_FIX_R: begin
          // Results land on the edge into DONE so they are valid alongside done
          r_reg <= r_neg ? add_sum : r_reg;
          hi    <= r_neg ? add_sum : r_reg;
          lo    <= q_reg;
          state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle signed 32-bit divider controller for the Mini-SRC ALU. It implements the DIV instruction by sequencing the team's existing 32-bit ripple adder/subtractor through a restoring-division algorithm, one quotient bit per cycle. It produces the quotient for LO and the remainder for HI. It sits beside the ALU and is started by the control unit, which waits on `done`.

## Interface
Parameters:
- `DATA_W`, 32: operand width. Only 32 is supported.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a division. Sampled only in IDLE.
- `dividend`, input, 32: signed dividend. Captured on an accepted `start`.
- `divisor`, input, 32: signed divisor. Captured on an accepted `start`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when results become valid.
- `lo`, output, 32: quotient. Held until the next accepted `start`.
- `hi`, output, 32: remainder. Held until the next accepted `start`.
- `div_by_zero`, output, 1: set with `done` when the divisor was 0; held with the results.

## Operation
- States:
  - IDLE
  - ABS_A
  - ABS_B
  - ITER
  - FIX_Q
  - FIX_R
  - DONE
- IDLE behaviour:
  - `start`=1 captures both operands, records `q_neg = sign(dividend) XOR sign(divisor)` and `r_neg = sign(dividend)`.
  - It clears `div_by_zero`, `lo` and `hi`.
  - If divisor == 0, go to DONE; otherwise go to ABS_A.
- ABS_A: replace the dividend by its magnitude; ABS_B: replace the divisor by its magnitude.
  - A negative operand is negated through the shared adder (A=0, B=x, sub=1).
  - A non-negative operand passes through unchanged.
- ITER runs exactly 32 cycles, counted by a 5-bit counter. Each cycle:
  - Shift {R,Q} left by 1.
  - Trial = R_shift − D, via the adder with sub=1.
  - If the adder's Cout=1 (no borrow): R ← trial and the Q LSB ← 1.
  - Else: keep R_shift and the Q LSB ← 0.
- Width rule: the magnitudes are ≤ 2^31 and R < D before each shift, so R_shift < 2^32. A 32-bit R with Cout as the compare result is exact and needs no 33rd bit.
- FIX_Q negates Q if `q_neg`. FIX_R negates R if `r_neg`. Both use the adder, and both states always take one cycle (fixed latency).
- The remainder takes the dividend's sign; the quotient truncates toward zero.
- DONE:
  - Latch `lo`=Q and `hi`=R, assert `done` for one cycle, then return to IDLE.
- Divide by zero:
  - Results are `lo`=32'hFFFF_FFFF, `hi`=dividend, `div_by_zero`=1.
- Overflow:
  - 0x8000_0000 / 0xFFFF_FFFF gives `lo`=0x8000_0000, `hi`=0, with no flag. The result wraps.
- `start` while `busy` is ignored, and the captured operands are unaffected.
- The adder is the only arithmetic resource: exactly one instance, muxed per state.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`, `done`, `div_by_zero` = 0.
  - `lo`, `hi` = 0.
  - The counter and internal registers = 0.
- Latency, with edge 0 being the edge that samples `start`:
  - Normal case: ABS_A in cycle 1, ABS_B in cycle 2, ITER in cycles 3–34, FIX_Q in 35, FIX_R in 36, DONE in 37. `done`=1 during cycle 37.
  - Divide by zero: DONE in cycle 1, so `done`=1 during cycle 1.
- `busy` rises in cycle 1 and falls when DONE exits. The earliest next start is therefore the edge ending cycle 38 (normal) or cycle 2 (divide by zero).
- `lo`, `hi` and `div_by_zero` change only in DONE and on an accepted `start`, which clears them.
- `rst` asserted at any time, including mid-ITER, forces the reset values immediately. No partial result is ever flagged `done`.

## Structure
- Shared package `mini_src_pkg`:
  - the `div_state_t` enum for the seven states;
  - `DIV_ITERS` = 32;
  - `DATA_W` = 32.
- One sub-module: the existing `adder`, instantiated once as the trial-subtract/negate unit. The state machine, counter and operand muxing stay in `div_ctrl`.

## Test plan
- 7 / 2: `done` in cycle 37, `lo`=3, `hi`=1, `div_by_zero`=0, `busy`=1 during cycles 1–37.
- −7 / 2 (0xFFFF_FFF9 / 2): `lo`=0xFFFF_FFFD (−3), `hi`=0xFFFF_FFFF (−1). Also 7 / −2 gives `lo`=−3, `hi`=1.
- 0x8000_0000 / 0xFFFF_FFFF: `lo`=0x8000_0000, `hi`=0. Also 0x8000_0000 / 1 gives `lo`=0x8000_0000, `hi`=0.
- 5 / 0: `done` in cycle 1, `lo`=0xFFFF_FFFF, `hi`=5, `div_by_zero`=1. A following 9 / 3 clears the flag and gives `lo`=3, `hi`=0.
- Pulse `start` with 100 / 7 at cycle 10 of a 50 / 5 operation:
  - The second `start` is ignored and the first completes with `lo`=10, `hi`=0.
  - Then assert `rst` at cycle 20 of a new operation: outputs are all 0, `busy`=0, and no `done` follows.
- 10,000 random signed pairs (nonzero divisor) checked against `$signed` / and %, and `done` is always exactly 37 cycles after `start`.
